// File: rtl/func_arbiter.sv
// func_arbiter: round-robin front end that shares one combinational FUNC
// datapath between N_REQ requesters. A granted request is latched onto the
// FUNC input group for a class-dependent number of cycles. The matching FUNC
// result is then held in a response register under a valid/ready handshake.
module func_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WORD_W   = 16,
  parameter int CARRY_W  = 1,
  parameter int CONF_W   = 4,
  parameter int MULT_LAT = 2,
  parameter int ID_W     = 2
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [N_REQ-1:0]            REQ_VALID,
  output logic [N_REQ-1:0]            REQ_READY,
  input  logic [N_REQ*CONF_W-1:0]     REQ_CONF,
  input  logic [N_REQ*2-1:0]          REQ_CLASS,
  input  logic [N_REQ*WORD_W-1:0]     REQ_A,
  input  logic [N_REQ*WORD_W-1:0]     REQ_B,
  input  logic [N_REQ*CARRY_W-1:0]    REQ_C_A,
  input  logic [N_REQ*CARRY_W-1:0]    REQ_C_B,
  output logic [CONF_W-1:0]           FU_CONF_ALU,
  output logic [1:0]                  FU_CLASS,
  output logic [WORD_W-1:0]           FU_A,
  output logic [WORD_W-1:0]           FU_B,
  output logic [CARRY_W-1:0]          FU_C_A,
  output logic [CARRY_W-1:0]          FU_C_B,
  input  logic [WORD_W-1:0]           FU_ADD_SUB_OUT,
  input  logic [WORD_W-1:0]           FU_MULT_OUT,
  input  logic [WORD_W-1:0]           FU_SHIFT_OUT,
  input  logic [WORD_W-1:0]           FU_LOGIC_OUT,
  input  logic [CARRY_W-1:0]          FU_ADD_SUB_OUT_C,
  input  logic [CARRY_W-1:0]          FU_MULT_OUT_C,
  input  logic [CARRY_W-1:0]          FU_SHIFT_OUT_C,
  input  logic [CARRY_W-1:0]          FU_LOGIC_OUT_C,
  output logic                        RSP_VALID,
  input  logic                        RSP_READY,
  output logic [ID_W-1:0]             RSP_ID,
  output logic [WORD_W-1:0]           RSP_DATA,
  output logic [CARRY_W-1:0]          RSP_C,
  output logic                        BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] CLS_ADD_SUB = 2'd0;
  localparam logic [1:0] CLS_MULT    = 2'd1;
  localparam logic [1:0] CLS_SHIFT   = 2'd2;
  localparam logic [1:0] CLS_LOGIC   = 2'd3;

  // The counter only has to hold MULT_LAT-1, the longest EXEC extension.
  localparam int             CNT_W    = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   cnt;
  logic               grant_any;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;
  logic [1:0]         grant_class;
  logic [WORD_W-1:0]  sel_data;
  logic [CARRY_W-1:0] sel_c;

  // Round-robin search: first valid index strictly after ptr, wrapping.
  // Scanning from the far end down lets the nearest hit win without a break.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (REQ_VALID[(int'(ptr) + k) % N_REQ]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  assign accept      = (state == S_IDLE) && grant_any;
  assign grant_class = REQ_CLASS[grant_idx*2 +: 2];

  // Pick the FUNC result that matches the latched operation class.
  always_comb begin
    sel_data = FU_ADD_SUB_OUT;
    sel_c    = FU_ADD_SUB_OUT_C;
    case (FU_CLASS)
      CLS_ADD_SUB: begin sel_data = FU_ADD_SUB_OUT; sel_c = FU_ADD_SUB_OUT_C; end
      CLS_MULT:    begin sel_data = FU_MULT_OUT;    sel_c = FU_MULT_OUT_C;    end
      CLS_SHIFT:   begin sel_data = FU_SHIFT_OUT;   sel_c = FU_SHIFT_OUT_C;   end
      CLS_LOGIC:   begin sel_data = FU_LOGIC_OUT;   sel_c = FU_LOGIC_OUT_C;   end
      default:     begin sel_data = FU_ADD_SUB_OUT; sel_c = FU_ADD_SUB_OUT_C; end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_any)     state_nxt = S_EXEC;
      S_EXEC:  if (cnt == '0)     state_nxt = S_RESP;
      S_RESP:  if (RSP_READY)     state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs; the grant is withheld while reset is asserted.
  always_comb begin
    REQ_READY = '0;
    if ((state == S_IDLE) && grant_any && RST_N) REQ_READY[grant_idx] = 1'b1;
    RSP_VALID = (state == S_RESP);
    BUSY      = (state != S_IDLE);
  end

  // Operation latch, EXEC counter and response capture. FU_* hold their
  // values outside EXEC so FUNC sees stable inputs until the next grant.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr         <= ID_W'(N_REQ - 1);
      cnt         <= '0;
      FU_CONF_ALU <= '0;
      FU_CLASS    <= '0;
      FU_A        <= '0;
      FU_B        <= '0;
      FU_C_A      <= '0;
      FU_C_B      <= '0;
      RSP_ID      <= '0;
      RSP_DATA    <= '0;
      RSP_C       <= '0;
    end else if (accept) begin
      ptr         <= grant_idx;
      RSP_ID      <= grant_idx;
      FU_CONF_ALU <= REQ_CONF[grant_idx*CONF_W +: CONF_W];
      FU_CLASS    <= grant_class;
      FU_A        <= REQ_A[grant_idx*WORD_W +: WORD_W];
      FU_B        <= REQ_B[grant_idx*WORD_W +: WORD_W];
      FU_C_A      <= REQ_C_A[grant_idx*CARRY_W +: CARRY_W];
      FU_C_B      <= REQ_C_B[grant_idx*CARRY_W +: CARRY_W];
      cnt         <= (grant_class == CLS_MULT) ? MULT_CNT : '0;
    end else if (state == S_EXEC) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        RSP_DATA <= sel_data;
        RSP_C    <= sel_c;
      end
    end
  end

endmodule

// File: tb/tb_func_arbiter.sv
// Self-checking bench for func_arbiter with a behavioural FUNC model and a
// response scoreboard (expected responses queued at grant, popped on handshake).
module tb_func_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int CW  = 1;
  localparam int CFW = 4;
  localparam int ML  = 3;
  localparam int IDW = 2;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [N-1:0]      REQ_VALID;
  logic [N-1:0]      REQ_READY;
  logic [N*CFW-1:0]  REQ_CONF;
  logic [N*2-1:0]    REQ_CLASS;
  logic [N*W-1:0]    REQ_A, REQ_B;
  logic [N*CW-1:0]   REQ_C_A, REQ_C_B;
  logic [CFW-1:0]    FU_CONF_ALU;
  logic [1:0]        FU_CLASS;
  logic [W-1:0]      FU_A, FU_B;
  logic [CW-1:0]     FU_C_A, FU_C_B;
  logic [W-1:0]      fu_add, fu_mult, fu_shift, fu_logic;
  logic [CW-1:0]     fu_add_c, fu_mult_c, fu_shift_c, fu_logic_c;
  logic              RSP_VALID, RSP_READY;
  logic [IDW-1:0]    RSP_ID;
  logic [W-1:0]      RSP_DATA;
  logic [CW-1:0]     RSP_C;
  logic              BUSY;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
    logic [CW-1:0]  c;
  } rsp_t;

  rsp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic ovr   = 1'b0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  func_arbiter #(
    .N_REQ(N), .WORD_W(W), .CARRY_W(CW), .CONF_W(CFW), .MULT_LAT(ML), .ID_W(IDW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_CONF(REQ_CONF), .REQ_CLASS(REQ_CLASS),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_C_A(REQ_C_A), .REQ_C_B(REQ_C_B),
    .FU_CONF_ALU(FU_CONF_ALU), .FU_CLASS(FU_CLASS),
    .FU_A(FU_A), .FU_B(FU_B), .FU_C_A(FU_C_A), .FU_C_B(FU_C_B),
    .FU_ADD_SUB_OUT(fu_add), .FU_MULT_OUT(fu_mult),
    .FU_SHIFT_OUT(fu_shift), .FU_LOGIC_OUT(fu_logic),
    .FU_ADD_SUB_OUT_C(fu_add_c), .FU_MULT_OUT_C(fu_mult_c),
    .FU_SHIFT_OUT_C(fu_shift_c), .FU_LOGIC_OUT_C(fu_logic_c),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA), .RSP_C(RSP_C),
    .BUSY(BUSY)
  );

  // FUNC model: ADD, MULT (low half), SHIFT-left, AND; ovr forces fixed values.
  logic [W:0]     add_full;
  logic [2*W-1:0] prod;
  assign add_full   = {1'b0, FU_A} + {1'b0, FU_B};
  assign prod       = FU_A * FU_B;
  assign fu_add     = ovr ? 16'hAAAA : add_full[W-1:0];
  assign fu_add_c   = ovr ? 1'b1 : add_full[W];
  assign fu_mult    = ovr ? 16'hBBBB : prod[W-1:0];
  assign fu_mult_c  = ovr ? 1'b1 : 1'b0;
  assign fu_shift   = ovr ? 16'h00F0 : (FU_A << FU_B[3:0]);
  assign fu_shift_c = ovr ? 1'b1 : 1'b0;
  assign fu_logic   = ovr ? 16'h1234 : (FU_A & FU_B);
  assign fu_logic_c = 1'b0;

  task automatic set_req(input int r, input logic [1:0] cls, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [CFW-1:0] conf,
                         input logic ca, input logic cb);
    REQ_CLASS[r*2 +: 2]   = cls;
    REQ_A[r*W +: W]       = a;
    REQ_B[r*W +: W]       = b;
    REQ_CONF[r*CFW +: CFW] = conf;
    REQ_C_A[r*CW +: CW]   = ca;
    REQ_C_B[r*CW +: CW]   = cb;
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  // Move to the sampling point of the current cycle and retire any response
  // handshake seen there against the scoreboard.
  task automatic settle();
    rsp_t e;
    @(negedge CLK);
    if (RST_N && RSP_VALID && RSP_READY) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got id=%0d data=%h c=%h, required no response",
                 RSP_ID, RSP_DATA, RSP_C);
      end else begin
        e = sb.pop_front();
        if (RSP_ID !== e.id || RSP_DATA !== e.data || RSP_C !== e.c) begin
          bad++;
          $display("FAIL rsp_data: got id=%0d data=%h c=%h, required id=%0d data=%h c=%h",
                   RSP_ID, RSP_DATA, RSP_C, e.id, e.data, e.c);
        end
      end
    end
  endtask

  task automatic drain();
    bit idle = 0;
    for (int k = 0; k < 20; k++) begin
      settle();
      if (!BUSY) begin idle = 1; break; end
      adv();
    end
    total++;
    if (!idle) begin bad++; $display("FAIL drain_timeout: got busy=%b, required 0", BUSY); end
    adv();
  endtask

  // Single request from requester r (only it valid); grant checked, response queued.
  task automatic do_op(input int r, input logic [1:0] cls, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_data,
                       input logic exp_c);
    logic [N-1:0] exp_rdy;
    exp_rdy    = '0;
    exp_rdy[r] = 1'b1;
    set_req(r, cls, a, b, 4'h0, 1'b0, 1'b0);
    REQ_VALID = exp_rdy;
    settle();
    total++;
    if (REQ_READY !== exp_rdy) begin
      bad++;
      $display("FAIL op_grant: got ready=%b, required %b", REQ_READY, exp_rdy);
    end
    sb.push_back('{id: IDW'(r), data: exp_data, c: exp_c});
    adv();
    REQ_VALID = '0;
    drain();
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    adv();
    adv();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N     = 1'b0;
    REQ_VALID = '1;
    #12;
    total++;
    if ({BUSY, RSP_VALID} !== 2'b00) begin
      bad++; $display("FAIL reset_status: got busy=%b valid=%b, required 0 0", BUSY, RSP_VALID);
    end
    total++;
    if (REQ_READY !== '0) begin
      bad++; $display("FAIL reset_ready: got %b, required 0000", REQ_READY);
    end
    total++;
    if ({RSP_ID, RSP_DATA, RSP_C} !== '0) begin
      bad++; $display("FAIL reset_rsp: got id=%0d data=%h c=%h, required 0 0 0", RSP_ID, RSP_DATA, RSP_C);
    end
    total++;
    if ({FU_CONF_ALU, FU_CLASS, FU_A, FU_B, FU_C_A, FU_C_B} !== '0) begin
      bad++; $display("FAIL reset_fu: got a=%h b=%h class=%0d, required all 0", FU_A, FU_B, FU_CLASS);
    end
    REQ_VALID = '0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    settle();
    total++;
    if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_idle: got busy=%b, required 0", BUSY); end
    adv();
  endtask

  task automatic test_single_add();
    set_req(2, 2'd0, 16'h0005, 16'h0003, 4'h1, 1'b0, 1'b0);
    REQ_VALID = 4'b0100;
    settle();
    total++;
    if (REQ_READY !== 4'b0100) begin
      bad++; $display("FAIL add_grant: got %b, required 0100", REQ_READY);
    end
    sb.push_back('{id: 2'd2, data: 16'h0008, c: 1'b0});
    adv();
    REQ_VALID = '0;
    settle();
    total++;
    if ({RSP_VALID, BUSY, FU_A} !== {1'b0, 1'b1, 16'h0005}) begin
      bad++; $display("FAIL add_exec: got valid=%b busy=%b fu_a=%h, required 0 1 0005", RSP_VALID, BUSY, FU_A);
    end
    adv();
    settle();
    total++;
    if ({RSP_VALID, RSP_ID} !== {1'b1, 2'd2}) begin
      bad++; $display("FAIL add_latency: got valid=%b id=%0d, required 1 2", RSP_VALID, RSP_ID);
    end
    adv();
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int last = 0;
    logic [N-1:0] exp_rdy;
    bit found;
    apply_reset();
    for (int i = 0; i < N; i++)
      set_req(i, 2'd0, 16'(16'h0100 * (i + 1)), 16'(i + 1), 4'h0, 1'b0, 1'b0);
    REQ_VALID = '1;
    for (int n = 0; n < 5; n++) begin
      found = 0;
      for (int k = 0; k < 10; k++) begin
        settle();
        if (REQ_READY !== '0) begin found = 1; break; end
        adv();
      end
      total++;
      if (!found) begin
        bad++; $display("FAIL rr_timeout: grant %0d got none, required one", n);
      end
      exp_rdy = '0;
      exp_rdy[order[n]] = 1'b1;
      total++;
      if (REQ_READY !== exp_rdy) begin
        bad++; $display("FAIL rr_order: grant %0d got %b, required %b", n, REQ_READY, exp_rdy);
      end
      sb.push_back('{id: IDW'(order[n]),
                     data: 16'(16'h0100 * (order[n] + 1) + order[n] + 1), c: 1'b0});
      if (n > 0) begin
        total++;
        if (cyc - last !== 3) begin
          bad++; $display("FAIL rr_spacing: grant %0d got %0d cycles, required 3", n, cyc - last);
        end
      end
      last = cyc;
      adv();
      if (n == 4) REQ_VALID = '0;
    end
    drain();
  endtask

  task automatic test_mult_latency();
    set_req(1, 2'd1, 16'h0007, 16'h0006, 4'hA, 1'b1, 1'b0);
    REQ_VALID = 4'b0010;
    settle();
    total++;
    if (REQ_READY !== 4'b0010) begin
      bad++; $display("FAIL mult_grant: got %b, required 0010", REQ_READY);
    end
    sb.push_back('{id: 2'd1, data: 16'h002A, c: 1'b0});
    adv();
    REQ_VALID = '0;
    for (int e = 0; e < ML; e++) begin
      settle();
      total++;
      if ({RSP_VALID, FU_A, FU_B, FU_CLASS, FU_CONF_ALU, FU_C_A, FU_C_B} !==
          {1'b0, 16'h0007, 16'h0006, 2'd1, 4'hA, 1'b1, 1'b0}) begin
        bad++; $display("FAIL mult_exec%0d: got valid=%b a=%h b=%h class=%0d conf=%h ca=%b, required 0 0007 0006 1 a 1",
                        e, RSP_VALID, FU_A, FU_B, FU_CLASS, FU_CONF_ALU, FU_C_A);
      end
      adv();
    end
    settle();
    total++;
    if (RSP_VALID !== 1'b1) begin
      bad++; $display("FAIL mult_latency: got valid=%b, required 1", RSP_VALID);
    end
    adv();
  endtask

  task automatic test_back_pressure();
    RSP_READY = 1'b0;
    set_req(3, 2'd0, 16'h1234, 16'h0F0F, 4'h0, 1'b0, 1'b0);
    set_req(0, 2'd0, 16'h0001, 16'h0002, 4'h0, 1'b0, 1'b0);
    REQ_VALID = 4'b1001;
    settle();
    total++;
    if (REQ_READY !== 4'b1000) begin
      bad++; $display("FAIL bp_grant: got %b, required 1000", REQ_READY);
    end
    sb.push_back('{id: 2'd3, data: 16'h2143, c: 1'b0});
    adv();
    REQ_VALID = 4'b0001;
    settle();
    adv();
    for (int k = 0; k < 5; k++) begin
      settle();
      total++;
      if ({RSP_VALID, RSP_DATA, RSP_ID, REQ_READY} !== {1'b1, 16'h2143, 2'd3, 4'b0000}) begin
        bad++; $display("FAIL bp_hold%0d: got valid=%b data=%h id=%0d ready=%b, required 1 2143 3 0000",
                        k, RSP_VALID, RSP_DATA, RSP_ID, REQ_READY);
      end
      adv();
    end
    RSP_READY = 1'b1;
    settle();
    total++;
    if (REQ_READY !== 4'b0000) begin
      bad++; $display("FAIL bp_release_ready: got %b, required 0000", REQ_READY);
    end
    adv();
    settle();
    total++;
    if (REQ_READY !== 4'b0001) begin
      bad++; $display("FAIL bp_next_grant: got %b, required 0001", REQ_READY);
    end
    sb.push_back('{id: 2'd0, data: 16'h0003, c: 1'b0});
    adv();
    REQ_VALID = '0;
    drain();
  endtask

  task automatic test_class_select();
    ovr = 1'b1;
    do_op(1, 2'd2, 16'h0011, 16'h0022, 16'h00F0, 1'b1);
    do_op(2, 2'd3, 16'h0033, 16'h0044, 16'h1234, 1'b0);
    do_op(3, 2'd0, 16'h0055, 16'h0066, 16'hAAAA, 1'b1);
    ovr = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    set_req(2, 2'd1, 16'h0003, 16'h0004, 4'h5, 1'b1, 1'b1);
    REQ_VALID = 4'b0100;
    settle();
    total++;
    if (REQ_READY !== 4'b0100) begin
      bad++; $display("FAIL rst_op_grant: got %b, required 0100", REQ_READY);
    end
    adv();
    REQ_VALID = '0;
    settle();
    total++;
    if (BUSY !== 1'b1) begin bad++; $display("FAIL rst_op_busy: got %b, required 1", BUSY); end
    adv();
    RST_N     = 1'b0;
    REQ_VALID = '1;
    #1;
    total++;
    if ({BUSY, RSP_VALID, REQ_READY} !== 6'b0) begin
      bad++; $display("FAIL rst_mid_status: got busy=%b valid=%b ready=%b, required 0 0 0000", BUSY, RSP_VALID, REQ_READY);
    end
    total++;
    if ({FU_CONF_ALU, FU_CLASS, FU_A, FU_B, FU_C_A, FU_C_B} !== '0) begin
      bad++; $display("FAIL rst_mid_fu: got a=%h b=%h class=%0d conf=%h, required all 0", FU_A, FU_B, FU_CLASS, FU_CONF_ALU);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    settle();
    total++;
    if (REQ_READY !== 4'b0001) begin
      bad++; $display("FAIL rst_first_grant: got %b, required 0001", REQ_READY);
    end
    sb.push_back('{id: 2'd0, data: 16'h0003, c: 1'b0});
    adv();
    REQ_VALID = '0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N     = 1'b0;
    REQ_VALID = '0;
    REQ_CONF  = '0;
    REQ_CLASS = '0;
    REQ_A     = '0;
    REQ_B     = '0;
    REQ_C_A   = '0;
    REQ_C_B   = '0;
    RSP_READY = 1'b1;
    test_reset();
    test_single_add();
    test_round_robin();
    test_mult_latency();
    test_back_pressure();
    test_class_select();
    test_reset_mid_op();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending responses, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
